mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified ram instance between the instruction-fetch (IF) port and the load/store (LSU) port.
//  Round-robin arbitration, valid/ready request handshake, one-cycle response pulse.
//  Checks alignment/access codes before touching ram; sequences ram load/store strobes for the configured read latency.
//  Sits between the core pipeline and ram.
// PARAMETERS
//  RD_LATENCY  1   cycles ram_load must be held before ram_data_out is sampled (>=1)
//  AW          32  address width
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  rst             in   1   synchronous, active-high reset
//  if_req_valid    in   1   IF requests a word fetch
//  if_req_ready    out  1   IF request accepted this cycle
//  if_addr         in   AW  fetch address (access fixed LW=3'b010)
//  if_resp_valid   out  1   one-cycle pulse, if_rdata/if_err valid
//  if_rdata        out  32  fetched word
//  if_err          out  1   misaligned fetch
//  lsu_req_valid   in   1   LSU request
//  lsu_req_ready   out  1   LSU request accepted this cycle
//  lsu_we          in   1   1=store, 0=load
//  lsu_access      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  lsu_addr        in   AW  byte address
//  lsu_wdata       in   32  store data, low bytes used
//  lsu_resp_valid  out  1   one-cycle pulse, lsu_rdata/lsu_err valid
//  lsu_rdata       out  32  load result as extended by ram; 0 for store/err
//  lsu_err         out  1   misaligned or illegal access
//  ram_load/ram_store out 1  ram strobes
//  ram_access      out  3   to ram
//  ram_addr        out  AW  to ram
//  ram_data_in     out  32  to ram
//  ram_data_out    in   32  from ram
// BEHAVIOUR
//  Reset: state=IDLE; last_grant=LSU, so the first tie goes to IF. All outputs 0; an in-flight request is dropped with no response.
//  FSM states: IDLE -> ISSUE -> RESP -> IDLE. An error request goes IDLE -> RESP directly.
//  IDLE
//   - req_ready is combinational, to the single winner.
//   - Only one valid: that port wins. Both valid: the port != last_grant wins.
//   - On the handshake cycle: register port, we, access, addr, wdata; last_grant<=winner.
//  Legality
//   - H/HU requires addr[0]==0; W requires addr[1:0]==0.
//   - Codes 011/110/111 are illegal.
//   - Store with 100/101 is illegal.
//  ISSUE
//   - Drives ram_* from the registered request.
//   - Store: ram_store=1 for exactly 1 cycle.
//   - Load: ram_load=1 for RD_LATENCY cycles (down-counter); ram_data_out is registered on the last cycle.
//  RESP
//   - resp_valid=1 for 1 cycle on the granted port only, with rdata/err.
//   - Other port's resp_* stay 0.
//  Outside ISSUE, all ram_* = 0.
//  Latency, in cycles after the accept edge:
//   - load: RD_LATENCY+1
//   - store: 2
//   - err: 1
//  Next accept no earlier than the cycle after RESP. req_ready=0 in ISSUE/RESP; requesters hold request fields stable until ready.
//  rst asserted in any state wins over everything on that edge.
// STRUCTURE
//  Package mima_mem_pkg:
//   - ACC_LB/LH/LW/LBU/LHU localparams
//   - typedef enum {PORT_IF, PORT_LSU}
//   - typedef enum {IDLE, ISSUE, RESP} arb_state_t
//  Sub-module mem_align_chk: combinational (access, addr[1:0], we) -> err.
//  Latency counter width $clog2(RD_LATENCY+1).
// TESTING
//  1. LSU SW addr 0 data 32'h00112233, then LW addr 0 -> ram_store 1 cycle; lsu_resp_valid at +2; LW rdata 32'h00112233 at +RD_LATENCY+1.
//  2. IF and LSU valid same cycle after reset, IF addr 4, LSU LBU addr 7 -> IF granted first, LSU next; IF rdata 32'hAABBCCDD, LSU rdata 32'h000000AA.
//  3. Both held valid for 6 transactions -> grants alternate IF, LSU, IF, ...; no starvation.
//  4. LSU LH addr 3, IF fetch addr 2, store access 3'b101 -> each err=1 at +1 cycle; ram_load/ram_store never asserted.
//  5. rst asserted during ISSUE of a load -> next cycle IDLE, all outputs 0, no resp_valid; next request serviced normally.
//  6. RD_LATENCY=3 build, LB addr 7 with byte 8'h88 -> ram_load high exactly 3 cycles; rdata 32'hFFFFFF88 at +4.

Source files
------------

// File: rtl/mima_mem_pkg.sv
// mima_mem_pkg: access codes and arbiter types shared by the memory port arbiter
package mima_mem_pkg;
    localparam logic [2:0] ACC_LB  = 3'b000;
    localparam logic [2:0] ACC_LH  = 3'b001;
    localparam logic [2:0] ACC_LW  = 3'b010;
    localparam logic [2:0] ACC_LBU = 3'b100;
    localparam logic [2:0] ACC_LHU = 3'b101;
    typedef enum logic {PORT_IF, PORT_LSU} port_t;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and ram bundles; master drives the request side
interface mem_fetch_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] addr;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          err;
    modport master (output req_valid, addr, input req_ready, resp_valid, rdata, err);
    modport slave  (input req_valid, addr, output req_ready, resp_valid, rdata, err);
endinterface

interface mem_req_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [2:0]    access;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          err;
    modport master (output req_valid, we, access, addr, wdata, input req_ready, resp_valid, rdata, err);
    modport slave  (input req_valid, we, access, addr, wdata, output req_ready, resp_valid, rdata, err);
endinterface

interface ram_if #(parameter int AW = 32);
    logic          load;
    logic          store;
    logic [2:0]    access;
    logic [AW-1:0] addr;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    modport master (output load, store, access, addr, data_in, input data_out);
    modport slave  (input load, store, access, addr, data_in, output data_out);
endinterface

// File: rtl/mem_align_chk.sv
// mem_align_chk: flags misaligned, unknown, or store-with-unsigned-code accesses
module mem_align_chk
    import mima_mem_pkg::*;
(
    input  logic [2:0] access,
    input  logic [1:0] addr_lo,
    input  logic       we,
    output logic       err
);
    logic bad_code;
    logic misaligned;
    assign bad_code   = access == 3'b011 || access[2:1] == 2'b11 || (we && access[2]);
    assign misaligned = ((access == ACC_LH || access == ACC_LHU) && addr_lo[0]) ||
                        (access == ACC_LW && addr_lo != 2'b00);
    assign err = bad_code || misaligned;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one ram between instruction fetch and load/store
module mem_port_arbiter
    import mima_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int AW         = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_fetch_if.slave fetch,
    mem_req_if.slave   lsu,
    ram_if.master      ram
);
    localparam int CW = $clog2(RD_LATENCY + 1);

    arb_state_t    state_q, state_d;
    port_t         last_q, last_d, port_q, port_d;
    logic          we_q, we_d, err_q, err_d, rv_q, rv_d, ld_q, ld_d, st_q, st_d;
    logic [2:0]    access_q, access_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          win_if, accept, sel_we, sel_err, issue, last_cycle;
    logic [2:0]    sel_access;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

    // On a tie the port that did not win last time gets the slot
    assign win_if     = fetch.req_valid && (!lsu.req_valid || last_q == PORT_LSU);
    assign accept     = state_q == IDLE && !rst && (fetch.req_valid || lsu.req_valid);
    assign fetch.req_ready = accept && win_if;
    assign lsu.req_ready   = accept && !win_if;

    assign sel_we     = win_if ? 1'b0 : lsu.we;
    assign sel_access = win_if ? ACC_LW : lsu.access;
    assign sel_addr   = win_if ? fetch.addr : lsu.addr;
    assign sel_wdata  = win_if ? '0 : lsu.wdata;

    mem_align_chk u_chk (
        .access  (sel_access),
        .addr_lo (sel_addr[1:0]),
        .we      (sel_we),
        .err     (sel_err)
    );

    assign issue      = state_q == ISSUE;
    assign last_cycle = we_q || cnt_q == CW'(1);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        port_d   = port_q;
        we_d     = we_q;
        access_d = access_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rv_d     = 1'b0;
        ld_d     = 1'b0;
        st_d     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = sel_err ? RESP : ISSUE;
                last_d   = win_if ? PORT_IF : PORT_LSU;
                port_d   = win_if ? PORT_IF : PORT_LSU;
                we_d     = sel_we;
                access_d = sel_access;
                addr_d   = sel_addr;
                wdata_d  = sel_wdata;
                err_d    = sel_err;
                cnt_d    = CW'(RD_LATENCY);
                rdata_d  = '0;
                rv_d     = sel_err;
                ld_d     = !sel_err && !sel_we;
                st_d     = !sel_err && sel_we;
            end
            ISSUE: if (last_cycle) begin
                state_d = RESP;
                rv_d    = 1'b1;
                rdata_d = we_q ? '0 : ram.data_out;
            end else begin
                cnt_d = cnt_q - CW'(1);
                ld_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= PORT_LSU;
            port_q   <= PORT_IF;
            we_q     <= 1'b0;
            access_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rv_q     <= 1'b0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            port_q   <= port_d;
            we_q     <= we_d;
            access_q <= access_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rv_q     <= rv_d;
            ld_q     <= ld_d;
            st_q     <= st_d;
        end
    end

    assign fetch.resp_valid = rv_q && port_q == PORT_IF;
    assign fetch.rdata      = fetch.resp_valid ? rdata_q : '0;
    assign fetch.err        = fetch.resp_valid && err_q;
    assign lsu.resp_valid   = rv_q && port_q == PORT_LSU;
    assign lsu.rdata        = lsu.resp_valid ? rdata_q : '0;
    assign lsu.err          = lsu.resp_valid && err_q;

    assign ram.load    = ld_q;
    assign ram.store   = st_q;
    assign ram.access  = issue ? access_q : '0;
    assign ram.addr    = issue ? addr_q : '0;
    assign ram.data_in = issue && we_q ? wdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, legality, latency and reset with a byte-lane ram model
module tb_mem_port_arbiter;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_load = 0;
    int   n_store = 0;
    int   ld_run = 0;
    logic [31:0] mem [16];
    logic [3:0]  smask;
    logic [31:0] sdata;

    mem_fetch_if #(.AW(32)) fi ();
    mem_req_if   #(.AW(32)) li ();
    ram_if       #(.AW(32)) ri ();

    mem_port_arbiter #(.RD_LATENCY(LAT), .AW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fi),
        .lsu   (li),
        .ram   (ri)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [2:0] acc, input logic [31:0] a);
        logic [31:0] sh;
        sh = mem[a[5:2]] >> (8 * a[1:0]);
        return acc == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               acc == 3'b100 ? {24'h0, sh[7:0]} :
               acc == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
               acc == 3'b101 ? {16'h0, sh[15:0]} : sh;
    endfunction

    // Read data only becomes valid once load has been held LAT cycles
    assign ri.data_out = (ri.load && ld_run >= LAT - 1) ? rd_val(ri.access, ri.addr) : 32'hDEADBEEF;
    assign smask = (ri.access[1:0] == 2'b00 ? 4'b0001 : ri.access[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << ri.addr[1:0];
    assign sdata = ri.data_in << (8 * ri.addr[1:0]);

    always @(posedge clk) begin
        if (ri.store)
            for (int k = 0; k < 4; k++)
                if (smask[k]) mem[ri.addr[5:2]][8*k +: 8] <= sdata[8*k +: 8];
        ld_run <= ri.load ? ld_run + 1 : 0;
        if (ri.load) n_load <= n_load + 1;
        if (ri.store) n_store <= n_store + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " if_resp_valid"}, {31'b0, fi.resp_valid}, 0);
        chk({tag, " lsu_resp_valid"}, {31'b0, li.resp_valid}, 0);
        chk({tag, " rdata/err"}, fi.rdata | li.rdata | {30'b0, fi.err, li.err}, 0);
        chk({tag, " ram strobes"}, {30'b0, ri.load, ri.store}, 0);
        chk({tag, " ram bus"}, ri.addr | ri.data_in | {29'b0, ri.access}, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    task automatic txn(input string tag, input bit is_if, input bit we, input logic [2:0] acc,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err, input int exp_lat, input int exp_ld, input int exp_st);
        int n, ld0, st0;
        if (is_if) begin
            fi.req_valid = 1'b1;
            fi.addr      = addr;
        end else begin
            li.req_valid = 1'b1;
            li.we        = we;
            li.access    = acc;
            li.addr      = addr;
            li.wdata     = wdata;
        end
        #1;
        n = 0;
        while (!(is_if ? fi.req_ready : li.req_ready) && n < 10) begin tick(); n++; end
        chk({tag, " ready"}, {31'b0, is_if ? fi.req_ready : li.req_ready}, 1);
        chk({tag, " other ready"}, {31'b0, is_if ? li.req_ready : fi.req_ready}, 0);
        ld0 = n_load;
        st0 = n_store;
        tick();
        fi.req_valid = 1'b0;
        li.req_valid = 1'b0;
        n = 1;
        while (!(is_if ? fi.resp_valid : li.resp_valid) && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " rdata"}, is_if ? fi.rdata : li.rdata, exp_rd);
        chk({tag, " err"}, {31'b0, is_if ? fi.err : li.err}, {31'b0, exp_err});
        chk({tag, " other resp"}, {31'b0, is_if ? li.resp_valid : fi.resp_valid}, 0);
        chk({tag, " load cycles"}, n_load - ld0, exp_ld);
        chk({tag, " store cycles"}, n_store - st0, exp_st);
        tick();
        chk({tag, " resp pulse"}, {30'b0, fi.resp_valid, li.resp_valid}, 0);
    endtask

    task automatic both_round(input int rounds);
        int k;
        bit exp_if;
        fi.req_valid = 1'b1;
        fi.addr      = 32'd4;
        li.req_valid = 1'b1;
        li.we        = 1'b0;
        li.access    = 3'b100;
        li.addr      = 32'd7;
        #1;
        for (int r = 0; r < rounds; r++) begin
            exp_if = (r % 2) == 0;
            k = 0;
            while (!(fi.req_ready || li.req_ready) && k < 10) begin tick(); k++; end
            chk($sformatf("rr%0d grant if", r), {31'b0, fi.req_ready}, {31'b0, exp_if});
            chk($sformatf("rr%0d grant lsu", r), {31'b0, li.req_ready}, {31'b0, !exp_if});
            tick();
            k = 1;
            while (!(fi.resp_valid || li.resp_valid) && k < 20) begin tick(); k++; end
            chk($sformatf("rr%0d latency", r), k, LAT + 1);
            chk($sformatf("rr%0d resp port", r), {30'b0, fi.resp_valid, li.resp_valid}, exp_if ? 2 : 1);
            chk($sformatf("rr%0d rdata", r), exp_if ? fi.rdata : li.rdata, exp_if ? 32'hAABBCCDD : 32'h000000AA);
            chk($sformatf("rr%0d ready in resp", r), {30'b0, fi.req_ready, li.req_ready}, 0);
            tick();
        end
        fi.req_valid = 1'b0;
        li.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fi.req_valid = 1'b0;
        fi.addr      = '0;
        li.req_valid = 1'b0;
        li.we        = 1'b0;
        li.access    = '0;
        li.addr      = '0;
        li.wdata     = '0;
        reset_dut();
        chk("reset ready", {30'b0, fi.req_ready, li.req_ready}, 0);

        txn("sw0", 0, 1, 3'b010, 32'd0, 32'h00112233, 32'h0, 0, 2, 0, 1);
        txn("lw0", 0, 0, 3'b010, 32'd0, 32'h0, 32'h00112233, 0, LAT + 1, LAT, 0);
        txn("sw4", 0, 1, 3'b010, 32'd4, 32'hAABBCCDD, 32'h0, 0, 2, 0, 1);

        reset_dut();
        both_round(6);

        txn("lh3", 0, 0, 3'b001, 32'd3, 32'h0, 32'h0, 1, 1, 0, 0);
        txn("if2", 1, 0, 3'b010, 32'd2, 32'h0, 32'h0, 1, 1, 0, 0);
        txn("st101", 0, 1, 3'b101, 32'd0, 32'h5, 32'h0, 1, 1, 0, 0);
        txn("st100", 0, 1, 3'b100, 32'd0, 32'h5, 32'h0, 1, 1, 0, 0);
        txn("ld011", 0, 0, 3'b011, 32'd0, 32'h0, 32'h0, 1, 1, 0, 0);
        txn("ld110", 0, 0, 3'b110, 32'd0, 32'h0, 32'h0, 1, 1, 0, 0);
        txn("lw2", 0, 0, 3'b010, 32'd2, 32'h0, 32'h0, 1, 1, 0, 0);
        txn("lhu1", 0, 0, 3'b101, 32'd1, 32'h0, 32'h0, 1, 1, 0, 0);

        li.req_valid = 1'b1;
        li.we        = 1'b0;
        li.access    = 3'b010;
        li.addr      = 32'd0;
        #1;
        chk("rst-mid ready", {31'b0, li.req_ready}, 1);
        tick();
        li.req_valid = 1'b0;
        tick();
        chk("rst-mid load in issue", {31'b0, ri.load}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst-mid");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst-mid quiet%0d", i), {29'b0, fi.resp_valid, li.resp_valid, ri.load}, 0);
        end
        txn("lw0 after rst", 0, 0, 3'b010, 32'd0, 32'h0, 32'h00112233, 0, LAT + 1, LAT, 0);

        txn("sb7", 0, 1, 3'b000, 32'd7, 32'h00000088, 32'h0, 0, 2, 0, 1);
        txn("lb7", 0, 0, 3'b000, 32'd7, 32'h0, 32'hFFFFFF88, 0, LAT + 1, LAT, 0);
        txn("lbu7", 0, 0, 3'b100, 32'd7, 32'h0, 32'h00000088, 0, LAT + 1, LAT, 0);
        txn("lhu6", 0, 0, 3'b101, 32'd6, 32'h0, 32'h000088BB, 0, LAT + 1, LAT, 0);
        txn("lh6", 0, 0, 3'b001, 32'd6, 32'h0, 32'hFFFF88BB, 0, LAT + 1, LAT, 0);
        txn("lh4", 0, 0, 3'b001, 32'd4, 32'h0, 32'hFFFFCCDD, 0, LAT + 1, LAT, 0);
        txn("if4", 1, 0, 3'b010, 32'd4, 32'h0, 32'h88BBCCDD, 0, LAT + 1, LAT, 0);
        txn("sh2", 0, 1, 3'b001, 32'd2, 32'h00001234, 32'h0, 0, 2, 0, 1);
        txn("lw0 after sh", 0, 0, 3'b010, 32'd0, 32'h0, 32'h12342233, 0, LAT + 1, LAT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
